// File: rtl/bcd_display_scan_pkg.sv
// Shared constants for the four-digit multiplexed seven-segment display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_display_scan_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [3:0] AN_OFF    = 4'b1111;

  function automatic logic nibble_invalid(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_display_scan_bcd_to_seg.sv
// Combinational BCD nibble to active-low segment pattern; codes 10-15 show a dash.
module bcd_to_seg
  import bcd_display_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment scanner with shadowed BCD input,
// optional leading-zero blanking and a one-cycle dark gap between digit slots.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        err
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       idx_reg;
  logic [15:0]      shadow_reg;
  logic [3:0]       shadow_dp_reg;
  logic [6:0]       seg_reg;
  logic             dp_n_reg;
  logic [3:0]       an_reg;
  logic             err_reg;

  logic             tick;
  logic [3:0]       nibble_sel;
  logic [6:0]       seg_decoded;
  logic [3:1]       zero_vec;
  logic [3:0]       blank_vec;
  logic [3:0]       bad_vec;
  logic             blank_now;

  assign tick       = (cnt_reg == CNT_MAX);
  assign nibble_sel = shadow_reg[idx_reg*4 +: 4];

  // Digit i is a leading zero when it and every more significant digit are zero.
  assign blank_vec[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lead
      assign zero_vec[gi]  = (shadow_reg[gi*4 +: 4] == 4'd0);
      assign blank_vec[gi] = &zero_vec[3:gi];
    end
    for (genvar gi = 0; gi < 4; gi++) begin : g_bad
      assign bad_vec[gi] = nibble_invalid(shadow_reg[gi*4 +: 4]);
    end
  endgenerate

  assign blank_now = blank_lz && blank_vec[idx_reg];

  bcd_to_seg u_dec (
    .bcd (nibble_sel),
    .seg (seg_decoded)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg       <= '0;
      idx_reg       <= 2'd0;
      shadow_reg    <= 16'h0000;
      shadow_dp_reg <= 4'h0;
      seg_reg       <= SEG_BLANK;
      dp_n_reg      <= 1'b1;
      an_reg        <= AN_OFF;
      err_reg       <= 1'b0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) idx_reg <= idx_reg + 2'd1;
      if (load) begin
        shadow_reg    <= digits;
        shadow_dp_reg <= dp_in;
      end
      // Outputs reflect the current idx, so they trail the index by one edge.
      if (tick) begin
        an_reg   <= AN_OFF;
        seg_reg  <= SEG_BLANK;
        dp_n_reg <= 1'b1;
      end else begin
        an_reg   <= ~(4'b0001 << idx_reg);
        seg_reg  <= blank_now ? SEG_BLANK : seg_decoded;
        dp_n_reg <= ~shadow_dp_reg[idx_reg];
      end
      err_reg <= |bad_vec;
    end
  end

  assign seg  = seg_reg;
  assign dp_n = dp_n_reg;
  assign an   = an_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with REFRESH_DIV=4: every slot is three lit
// cycles followed by one dark cycle; edge k after reset release shows digit (k/4)%4.
module tb_bcd_display_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic        err;

  int total = 0;
  int bad = 0;
  int edge_k = -1;

  bcd_display_scan #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .digits   (digits),
    .dp_in    (dp_in),
    .blank_lz (blank_lz),
    .seg      (seg),
    .dp_n     (dp_n),
    .an       (an),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after edge number 'target' (counted from reset release).
  task automatic go(input int target);
    while (edge_k < target) begin
      @(posedge clk);
      #1;
      edge_k++;
    end
  endtask

  task automatic show(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
    chk({tag, "_an"}, {12'h0, an}, {12'h0, exp_an});
    chk({tag, "_seg"}, {9'h0, seg}, {9'h0, exp_seg});
    $display("step %s: an=%b seg=%b dp_n=%b err=%b", tag, an, seg, dp_n, err);
  endtask

  initial begin
    // Reset held for three edges
    repeat (3) @(posedge clk);
    #1;
    show("rst_hold", 4'b1111, 7'b1111111);
    chk("rst_err", {15'h0, err}, 16'h0);
    chk("rst_dpn", {15'h0, dp_n}, 16'h1);
    reset = 1'b1;
    edge_k = -1;
    go(0);
    show("rst_first", 4'b1110, 7'b1000000);

    // Scan of 1234; digits changed while load=0 must not disturb the display
    load = 1'b1; digits = 16'h1234;
    go(1);
    load = 1'b0; digits = 16'h5555;
    go(2);  show("scan_d0", 4'b1110, 7'b0011001);
    chk("scan_d0_dpn", {15'h0, dp_n}, 16'h1);
    go(3);  show("scan_gap0", 4'b1111, 7'b1111111);
    go(5);  show("scan_d1", 4'b1101, 7'b0110000);
    go(7);  show("scan_gap1", 4'b1111, 7'b1111111);
    go(9);  show("scan_d2", 4'b1011, 7'b0100100);
    go(13); show("scan_d3", 4'b0111, 7'b1111001);
    go(15); show("scan_gap3", 4'b1111, 7'b1111111);

    // Leading-zero blanking with 0050, decimal point on digit 2
    load = 1'b1; digits = 16'h0050; dp_in = 4'b0100; blank_lz = 1'b1;
    go(16);
    load = 1'b0;
    go(17); show("blz_d0", 4'b1110, 7'b1000000);
    go(21); show("blz_d1", 4'b1101, 7'b0010010);
    go(25); show("blz_d2", 4'b1011, 7'b1111111);
    chk("blz_d2_dpn", {15'h0, dp_n}, 16'h0);
    go(29); show("blz_d3", 4'b0111, 7'b1111111);
    chk("blz_d3_dpn", {15'h0, dp_n}, 16'h1);

    // All-zero: only digit 0 lit
    load = 1'b1; digits = 16'h0000; dp_in = 4'h0;
    go(30);
    load = 1'b0;
    go(32); show("zero_d0", 4'b1110, 7'b1000000);
    go(36); show("zero_d1", 4'b1101, 7'b1111111);
    go(40); show("zero_d2", 4'b1011, 7'b1111111);
    go(44); show("zero_d3", 4'b0111, 7'b1111111);

    // Invalid nibble A in digit 2
    go(45);
    blank_lz = 1'b0; load = 1'b1; digits = 16'h1A09;
    go(46);
    load = 1'b0;
    chk("inv_err_lag", {15'h0, err}, 16'h0);
    go(47);
    chk("inv_err_set", {15'h0, err}, 16'h1);
    go(48); show("inv_d0", 4'b1110, 7'b0010000);
    go(52); show("inv_d1", 4'b1101, 7'b1000000);
    go(56); show("inv_d2", 4'b1011, 7'b0111111);
    go(57);
    load = 1'b1; digits = 16'h1209;
    go(58);
    load = 1'b0;
    chk("inv_err_hold", {15'h0, err}, 16'h1);
    go(59);
    chk("inv_err_clr", {15'h0, err}, 16'h0);

    // Load on the tick edge 67 (idx 0 -> 1); digit 1 was 0, becomes 9
    go(66);
    load = 1'b1; digits = 16'h9999;
    go(67);
    load = 1'b0;
    show("col_gap", 4'b1111, 7'b1111111);
    go(68); show("col_d1", 4'b1101, 7'b0010000);

    // Asynchronous reset while idx=2, between clock edges
    go(73);
    #2;
    reset = 1'b0;
    #1;
    show("mid_rst", 4'b1111, 7'b1111111);
    chk("mid_rst_dpn", {15'h0, dp_n}, 16'h1);
    chk("mid_rst_err", {15'h0, err}, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    edge_k = -1;
    go(0);  show("post_d0", 4'b1110, 7'b1000000);
    go(4);  show("post_d1", 4'b1101, 7'b1000000);
    go(12); show("post_d3", 4'b0111, 7'b1000000);
    chk("post_err", {15'h0, err}, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles per digit slot; legal range is at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load, input, 1 bit: when high at an edge, digits and dp_in are captured into the shadow registers.
REQ-005 SHALL have port digits, input, 16 bits: four BCD nibbles; [3:0] is digit 0 (least significant), [15:12] is digit 3.
REQ-006 SHALL have port dp_in, input, 4 bits: decimal-point request per digit, active-high.
REQ-007 SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable, sampled live (not shadowed).
REQ-008 SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-009 SHALL have port dp_n, output, 1 bit: decimal point, active-low, registered.
REQ-010 SHALL have port an, output, 4 bits: digit anodes, active-low one-hot, registered.
REQ-011 SHALL have port err, output, 1 bit: high while any shadow nibble exceeds 9, registered.

Function
REQ-012 SHALL use a prescaler cnt counting 0..REFRESH_DIV-1 and wrapping to 0; tick is high when cnt == REFRESH_DIV-1.
REQ-013 SHALL use a digit index idx (2 bits) that advances on tick and wraps from 3 to 0.
REQ-014 SHALL, at an edge where tick is high, drive an=4'b1111, seg=7'b1111111 and dp_n=1 (one-cycle dead time to prevent ghosting).
REQ-015 SHALL, at an edge where tick is low, drive an low only at bit idx, seg=decode(shadow[idx]) and dp_n=~shadow_dp[idx], so outputs lag idx by one cycle.
REQ-016 SHALL decode BCD as: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-017 SHALL decode nibbles 10-15 as a dash, 0111111.
REQ-018 SHALL, when blank_lz=1, blank digit i (seg=1111111, dp_n still per dp) when shadow digits i..3 are all zero, for i>=1; digit 0 is never blanked.
REQ-019 SHALL keep an asserted for a blanked digit, so the scan timing is unchanged.
REQ-020 SHALL, when load and tick occur in the same cycle, both capture the shadow and advance idx; the next output uses the new shadow.
REQ-021 SHALL update err one cycle after the shadow changes, and it is non-sticky.
REQ-022 SHALL leave the shadow, and therefore the display, unchanged while load=0, regardless of digits.

Reset
REQ-023 SHALL, while reset=0, asynchronously force cnt=0, idx=0, shadow=0, shadow_dp=0, an=1111, seg=1111111, dp_n=1, err=0.
REQ-024 SHALL, on the first edge after reset release, drive an=1110 and seg=1000000 (digit 0 showing 0).

Structure
REQ-025 SHALL place the segment code constants (digit 0-9, DASH, BLANK) and the anode-off constant in the shared display package.
REQ-026 SHALL implement the BCD-to-segment conversion as a combinational sub-module bcd_to_seg (4-bit in, 7-bit out), instantiated once on the muxed nibble.

Verification (REFRESH_DIV=4)
REQ-027 SHALL cover reset: hold reset=0 for 3 cycles -> an=1111, seg=1111111, err=0; release -> next edge an=1110, seg=1000000.
REQ-028 SHALL cover a scan: load digits=16'h1234 -> per 4-cycle slot an 1110/seg 0011001, then 1101/0110000, then 1011/0100100, then 0111/1111001, with one an=1111 cycle at each slot boundary.
REQ-029 SHALL cover blanking: blank_lz=1 with digits=16'h0050 -> digits 3 and 2 show seg=1111111, digit 1 shows 0010010, digit 0 shows 1000000; with 16'h0000 only digit 0 is lit.
REQ-030 SHALL cover an invalid code: load 16'h1A09 -> err=1 one cycle after the shadow update and digit 2 shows 0111111; then load 16'h1209 -> err=0.
REQ-031 SHALL cover load colliding with tick: load 16'h9999 on a tick cycle -> next slot shows 0010000 on the advanced digit.
REQ-032 SHALL cover reset mid-scan: assert reset while idx=2 -> outputs go to their reset values without waiting for clk, and the shadow reads 0 after release.
